// File: rtl/xbus_dma.sv
// rtl/xbus_dma.sv - single-channel xbus block-copy initiator
// Copies len words from src to dst, one read-latency-write triple per word.
`ifndef XADDRW
`define XADDRW 32
`endif
`ifndef XDATAW
`define XDATAW 32
`endif
`ifndef XBYTEC
`define XBYTEC 4
`endif

module xbus_dma #(
  parameter int LENW = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [`XADDRW-1:0]   src,
  input  logic [`XADDRW-1:0]   dst,
  input  logic [LENW-1:0]      len,
  output logic                 busy,
  output logic                 done,
  output logic [LENW-1:0]      count,
  output logic                 xbus_cs,
  output logic                 xbus_we,
  output logic [`XBYTEC-1:0]   xbus_be,
  output logic [`XADDRW-1:0]   xbus_addr,
  output logic [`XDATAW-1:0]   xbus_wdata,
  input  logic [`XDATAW-1:0]   xbus_rdata
);

  typedef enum logic [1:0] {IDLE, RD, LAT, WR} state_t;

  localparam logic [`XADDRW-1:0] ALIGN_MASK = {{(`XADDRW-2){1'b1}}, 2'b00};
  localparam logic [`XADDRW-1:0] WORD_STEP  = `XADDRW'(4);

  state_t               state_q, state_d;
  logic [`XADDRW-1:0]   src_q, src_d, dst_q, dst_d;
  logic [LENW-1:0]      rem_q, rem_d, count_q, count_d;
  logic [`XDATAW-1:0]   data_q, data_d;
  logic                 done_q, done_d;
  logic                 cs_q, cs_d, we_q, we_d;
  logic [`XBYTEC-1:0]   be_q, be_d;
  logic [`XADDRW-1:0]   addr_q, addr_d;
  logic [`XDATAW-1:0]   wdata_q, wdata_d;

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    rem_d   = rem_q;
    count_d = count_q;
    data_d  = data_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          count_d = '0;
          if (len != '0) begin
            src_d   = src & ALIGN_MASK;
            dst_d   = dst & ALIGN_MASK;
            rem_d   = len;
            state_d = RD;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      RD:  state_d = abort ? IDLE : LAT;
      LAT: begin
        data_d  = xbus_rdata;
        state_d = abort ? IDLE : WR;
      end
      WR: begin
        // The write is already on the bus, so it is counted even when aborted.
        src_d   = src_q + WORD_STEP;
        dst_d   = dst_q + WORD_STEP;
        rem_d   = rem_q - LENW'(1);
        count_d = count_q + LENW'(1);
        if (abort) begin
          state_d = IDLE;
        end else if (rem_q == LENW'(1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = RD;
        end
      end
      default: state_d = IDLE;
    endcase

    // Bus outputs are registered from the upcoming state.
    cs_d    = (state_d == RD) || (state_d == WR);
    we_d    = (state_d == WR);
    be_d    = we_d ? '1 : '0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (state_d == RD) addr_d = src_d;
    if (state_d == WR) begin
      addr_d  = dst_d;
      wdata_d = data_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      rem_q   <= '0;
      count_q <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      cs_q    <= 1'b0;
      we_q    <= 1'b0;
      be_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      rem_q   <= rem_d;
      count_q <= count_d;
      data_q  <= data_d;
      done_q  <= done_d;
      cs_q    <= cs_d;
      we_q    <= we_d;
      be_q    <= be_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign busy       = (state_q != IDLE);
  assign done       = done_q;
  assign count      = count_q;
  assign xbus_cs    = cs_q;
  assign xbus_we    = we_q;
  assign xbus_be    = be_q;
  assign xbus_addr  = addr_q;
  assign xbus_wdata = wdata_q;

endmodule

// File: tb/tb_xbus_dma.sv
// tb/tb_xbus_dma.sv - directed bench for xbus_dma
`timescale 1ns/1ps

module tb_xbus_dma;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [31:0] src = '0;
    logic [31:0] dst = '0;
    logic [15:0] len = '0;
    logic        busy, done;
    logic [15:0] count;
    logic        xbus_cs, xbus_we;
    logic [3:0]  xbus_be;
    logic [31:0] xbus_addr, xbus_wdata;
    logic [31:0] xbus_rdata = '0;

    int checks = 0;
    int errors = 0;
    int cyc;
    int cs_cycles;
    int busy_cycles;

    logic [31:0] mem [0:255];
    logic [31:0] rd_q [$];
    logic [31:0] wa_q [$];
    logic [31:0] wd_q [$];
    logic [3:0]  wb_q [$];

    xbus_dma #(.LENW(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .src(src), .dst(dst), .len(len),
        .busy(busy), .done(done), .count(count),
        .xbus_cs(xbus_cs), .xbus_we(xbus_we), .xbus_be(xbus_be),
        .xbus_addr(xbus_addr), .xbus_wdata(xbus_wdata), .xbus_rdata(xbus_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (xbus_cs && !xbus_we) xbus_rdata <= mem[xbus_addr[9:2]];
    end

    always @(negedge clk) begin
        if (xbus_cs) begin
            cs_cycles++;
            if (xbus_we) begin
                wa_q.push_back(xbus_addr);
                wd_q.push_back(xbus_wdata);
                wb_q.push_back(xbus_be);
            end else begin
                rd_q.push_back(xbus_addr);
            end
        end
        if (busy) busy_cycles++;
    end

    task automatic chk(input string tag, input bit ok, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        rd_q.delete(); wa_q.delete(); wd_q.delete(); wb_q.delete();
        cs_cycles = 0;
        busy_cycles = 0;
    endtask

    task automatic kick(input logic [31:0] s, input logic [31:0] d, input logic [15:0] l);
        @(posedge clk); #1;
        src = s; dst = d; len = l; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1;
    endtask

    task automatic wait_done(input int max_cyc);
        while (!done && cyc < max_cyc) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("done_timeout", done === 1'b1, done, 1'b1);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'hC0DE_0000 + i;
        mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33; mem[3] = 32'h44;
        mem[8'h40] = 32'hA5A5_0001;
        mem[8'hFE] = 32'hFE00_00FE;
        mem[8'hFF] = 32'hFF00_00FF;

        #12;
        chk("rst_busy", busy === 1'b0, busy, 1'b0);
        chk("rst_done", done === 1'b0, done, 1'b0);
        chk("rst_count", count === 16'h0, count, 16'h0);
        chk("rst_cs", xbus_cs === 1'b0, xbus_cs, 1'b0);
        chk("rst_addr", xbus_addr === 32'h0, xbus_addr, 32'h0);
        chk("rst_wdata", xbus_wdata === 32'h0, xbus_wdata, 32'h0);
        @(posedge clk); #1 rst_n = 1'b1;
        clear_log();

        kick(32'h0, 32'h1000, 16'd4);
        chk("t1_busy", busy === 1'b1, busy, 1'b1);
        wait_done(40);
        chk("t1_latency", cyc === 13, cyc, 13);
        chk("t1_count", count === 16'd4, count, 16'd4);
        chk("t1_busy_at_done", busy === 1'b0, busy, 1'b0);
        chk("t1_nrd", rd_q.size() === 4, rd_q.size(), 4);
        chk("t1_nwr", wa_q.size() === 4, wa_q.size(), 4);
        if (rd_q.size() == 4 && wa_q.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                chk("t1_rd_addr", rd_q[i] === 32'(4 * i), rd_q[i], 32'(4 * i));
                chk("t1_wr_addr", wa_q[i] === 32'h1000 + 32'(4 * i), wa_q[i], 32'h1000 + 32'(4 * i));
                chk("t1_wr_data", wd_q[i] === 32'h11 * 32'(i + 1), wd_q[i], 32'h11 * 32'(i + 1));
                chk("t1_wr_be", wb_q[i] === 4'hF, wb_q[i], 4'hF);
            end
        end
        @(posedge clk); #1;
        chk("t1_done_drop", done === 1'b0, done, 1'b0);

        clear_log();
        kick(32'h103, 32'h2002, 16'd1);
        wait_done(20);
        chk("t2_latency", cyc === 4, cyc, 4);
        chk("t2_nrd", rd_q.size() === 1, rd_q.size(), 1);
        chk("t2_nwr", wa_q.size() === 1, wa_q.size(), 1);
        if (rd_q.size() == 1 && wa_q.size() == 1) begin
            chk("t2_rd_addr", rd_q[0] === 32'h100, rd_q[0], 32'h100);
            chk("t2_wr_addr", wa_q[0] === 32'h2000, wa_q[0], 32'h2000);
            chk("t2_wr_data", wd_q[0] === 32'hA5A5_0001, wd_q[0], 32'hA5A5_0001);
        end
        @(posedge clk); #1;
        chk("t2_done_width", done === 1'b0, done, 1'b0);

        clear_log();
        kick(32'h40, 32'h80, 16'd0);
        chk("t3_done", done === 1'b1, done, 1'b1);
        chk("t3_count", count === 16'd0, count, 16'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("t3_done_drop", done === 1'b0, done, 1'b0);
        chk("t3_cs_cycles", cs_cycles === 0, cs_cycles, 0);
        chk("t3_busy_cycles", busy_cycles === 0, busy_cycles, 0);

        clear_log();
        kick(32'h200, 32'h3000, 16'd8);
        while (cyc < 9) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("t4_in_wr", xbus_we === 1'b1, xbus_we, 1'b1);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("t4_busy", busy === 1'b0, busy, 1'b0);
        chk("t4_done", done === 1'b0, done, 1'b0);
        chk("t4_count", count === 16'd3, count, 16'd3);
        @(posedge clk); #1;
        chk("t4_done_late", done === 1'b0, done, 1'b0);
        chk("t4_nwr", wa_q.size() === 3, wa_q.size(), 3);
        chk("t4_nrd", rd_q.size() === 3, rd_q.size(), 3);
        if (wa_q.size() == 3) begin
            chk("t4_last_wr_addr", wa_q[2] === 32'h3008, wa_q[2], 32'h3008);
            chk("t4_last_wr_data", wd_q[2] === 32'hC0DE_0082, wd_q[2], 32'hC0DE_0082);
        end

        clear_log();
        kick(32'hFFFF_FFF8, 32'h4000, 16'd3);
        while (cyc < 4) begin
            @(posedge clk); #1;
            cyc++;
        end
        src = 32'h800; len = 16'd1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc++;
        wait_done(40);
        chk("t5_latency", cyc === 10, cyc, 10);
        chk("t5_count", count === 16'd3, count, 16'd3);
        chk("t5_nrd", rd_q.size() === 3, rd_q.size(), 3);
        if (rd_q.size() == 3 && wd_q.size() == 3) begin
            chk("t5_rd0", rd_q[0] === 32'hFFFF_FFF8, rd_q[0], 32'hFFFF_FFF8);
            chk("t5_rd1", rd_q[1] === 32'hFFFF_FFFC, rd_q[1], 32'hFFFF_FFFC);
            chk("t5_rd2", rd_q[2] === 32'h0000_0000, rd_q[2], 32'h0000_0000);
            chk("t5_wd2", wd_q[2] === 32'h11, wd_q[2], 32'h11);
        end

        clear_log();
        kick(32'h0, 32'h5000, 16'd4);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("t6_in_wr", xbus_we === 1'b1, xbus_we, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        chk("t6_rst_cs", xbus_cs === 1'b0, xbus_cs, 1'b0);
        chk("t6_rst_we", xbus_we === 1'b0, xbus_we, 1'b0);
        chk("t6_rst_be", xbus_be === 4'h0, xbus_be, 4'h0);
        chk("t6_rst_addr", xbus_addr === 32'h0, xbus_addr, 32'h0);
        chk("t6_rst_wdata", xbus_wdata === 32'h0, xbus_wdata, 32'h0);
        chk("t6_rst_busy", busy === 1'b0, busy, 1'b0);
        chk("t6_rst_count", count === 16'h0, count, 16'h0);
        @(posedge clk); #1 rst_n = 1'b1;
        clear_log();
        kick(32'h4, 32'h6000, 16'd2);
        wait_done(30);
        chk("t6_latency", cyc === 7, cyc, 7);
        chk("t6_count", count === 16'd2, count, 16'd2);
        chk("t6_nwr", wa_q.size() === 2, wa_q.size(), 2);
        if (wa_q.size() == 2) begin
            chk("t6_wa1", wa_q[1] === 32'h6004, wa_q[1], 32'h6004);
            chk("t6_wd1", wd_q[1] === 32'h33, wd_q[1], 32'h33);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
